serial_mem_responder: RTL
=========================

Name: serial_mem_responder

Overview:
- Memory-side responder for the CPU core's 8-bit byte-serial bus.
- Accepts address and write-data bytes from the CPU, keyed by the bus_pc, bus_mar and bus_mdr strobes. Returns 16-bit read words as two bytes using the ard_data_ready / ard_receive_ready handshake.
- Backed by an internal synchronous word memory. A testbench/loader backdoor port is provided.
- Lets the CPU run on an FPGA or in simulation without the external microcontroller.

Parameters:
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W 16-bit words.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- cpu_bus  input  8  byte driven by the CPU
- bus_pc  input  1  CPU byte is part of an instruction-fetch request
- bus_mar  input  1  CPU byte is part of a data-read request
- bus_mdr  input  1  CPU byte is part of a data-write request
- cpu_rd_ack  input  1  CPU consumes the byte on rsp_bus this cycle
- halt  input  1  CPU halted; responder idles
- ld_en  input  1  backdoor write enable
- ld_addr  input  ADDR_W  backdoor word address
- ld_data  input  16  backdoor word data
- rsp_bus  output  8  byte returned to the CPU
- ard_data_ready  output  1  rsp_bus holds a valid byte
- ard_receive_ready  output  1  responder accepts a CPU byte this cycle
- err  output  1  sticky protocol-error flag

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on the rising edge of clk).
- Reset: state=IDLE, err=0, rsp_bus=0, ard_data_ready=0. ard_receive_ready=1 from the first cycle after reset if halt=0. Memory contents are not reset.
- Byte accept rule: a CPU byte is accepted when exactly one strobe is high AND ard_receive_ready=1.
- Byte return rule: a returned byte is consumed when ard_data_ready=1 AND cpu_rd_ack=1.
- Byte order is low byte first. Address bits above ADDR_W are ignored.
- States and transitions:
  - IDLE: ard_receive_ready=1. First byte (addr lo) latches the strobe kind → ADDR_HI.
  - ADDR_HI: ard_receive_ready=1. On accept: pc/mar kind → RD_WAIT (memory read issued); mdr kind → WDATA_LO.
  - WDATA_LO: ard_receive_ready=1. On accept → WDATA_HI.
  - WDATA_HI: ard_receive_ready=1. On accept, the memory word is written at that edge → IDLE.
  - RD_WAIT: one cycle, synchronous memory read → SEND_LO.
  - SEND_LO: ard_data_ready=1, rsp_bus=data[7:0]. On cpu_rd_ack → SEND_HI.
  - SEND_HI: ard_data_ready=1, rsp_bus=data[15:8]. On cpu_rd_ack → IDLE.
- Read latency: the SEND_LO byte is presented 2 cycles after the addr-hi byte is accepted.
- Read data is latched. A backdoor write to the same address during SEND_* does not change the bytes being returned.
- ard_receive_ready=0 in RD_WAIT, SEND_*, and whenever halt=1.
- ard_data_ready=0 outside SEND_*. rsp_bus=0 whenever ard_data_ready=0.
- Protocol errors:
  - More than one strobe high in a cycle: byte ignored, err set, state unchanged.
  - Mid-transaction byte whose strobe differs from the latched kind: err set, transaction aborted → IDLE, no memory write.
  - err clears only on rst.
- halt=1: state forced to IDLE at the next edge and any partial transaction is discarded. A pending write without its hi byte is never committed.
- Backdoor: ld_en writes ld_data at ld_addr at the edge, in any state. If it coincides with a CPU write commit, the ld write wins when the addresses match. The CPU write still completes when the addresses differ.
- cpu_rd_ack while ard_data_ready=0: ignored.
- Strobes in SEND_*: ignored, no error.

Decomposition:
- Shared package (e.g. cpu_types) holds:
  - state enum resp_state_t {IDLE, ADDR_HI, WDATA_LO, WDATA_HI, RD_WAIT, SEND_LO, SEND_HI}
  - xfer kind enum {XFER_PC, XFER_MAR, XFER_MDR}
  - WORD_W=16, BYTE_W=8
- One sub-module: resp_mem. It is a 2**ADDR_W x 16 synchronous RAM with one read port and one write port. The write port is arbitrated inside the responder (ld priority).

Test Plan:
- Backdoor load: ld 0x12=0xBEEF. Then bus_mar bytes 0x12, 0x00 → rsp_bus 0xEF, then 0xBE after ack. ard_data_ready rises exactly 2 cycles after the hi byte is accepted.
- Write then fetch: bus_mdr bytes 0x05, 0x00, 0x34, 0x12. Then bus_pc bytes 0x05, 0x00 → returns 0x34, 0x12. Address hi byte 0xFF with ADDR_W=8 aliases to the same word.
- CPU stalls ack 5 cycles in SEND_LO: rsp_bus holds 0xEF and ard_data_ready stays 1. A ld to the same address during the stall does not alter the returned bytes.
- Protocol error: bus_pc and bus_mar high together → err=1, state stays IDLE. Also bus_mdr addr lo followed by a bus_mar byte → err=1, abort, memory unchanged.
- halt asserted after the second write byte → ard_receive_ready=0, state IDLE, word not written. After halt deasserts, a fresh read returns the old value.
- rst asserted in SEND_HI → next cycle ard_data_ready=0, rsp_bus=0, err=0, ard_receive_ready=1, memory contents preserved.

Source files
------------

// File: rtl/serial_mem_responder_pkg.sv
// Shared types and widths for the byte-serial memory responder.
package serial_mem_responder_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  // Responder protocol states.
  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    WDATA_LO,
    WDATA_HI,
    RD_WAIT,
    SEND_LO,
    SEND_HI
  } resp_state_t;

  // Kind of CPU transfer, taken from whichever strobe carried the first byte.
  typedef enum logic [1:0] {
    XFER_PC,
    XFER_MAR,
    XFER_MDR
  } xfer_kind_t;

  // Maps a single active strobe to its transfer kind.
  function automatic xfer_kind_t strobe_kind(input logic pc, input logic mar);
    if (pc) return XFER_PC;
    if (mar) return XFER_MAR;
    return XFER_MDR;
  endfunction

endpackage

// File: rtl/serial_mem_responder_resp_mem.sv
// 2**ADDR_W x 16 synchronous RAM, one registered read port and one write port.
// A read of the address being written on the same edge returns the old word.
module resp_mem
  import serial_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // Write and registered read; rd_data holds its value while rd_en is low.
  // NOTE: the array and its read register have no reset -- RAM macros cannot
  // be reset, and contents must survive a responder reset anyway.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/serial_mem_responder.sv
// Memory-side responder for the CPU's byte-serial bus. Collects address and
// write-data bytes (low byte first), returns 16-bit read words as two bytes,
// and shares the RAM write port with a loader backdoor (ld has priority).
// ADDR_W must be between 1 and 16.
module serial_mem_responder
  import serial_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] cpu_bus,
  input  logic              bus_pc,
  input  logic              bus_mar,
  input  logic              bus_mdr,
  input  logic              cpu_rd_ack,
  input  logic              halt,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WORD_W-1:0] ld_data,
  output logic [BYTE_W-1:0] rsp_bus,
  output logic              ard_data_ready,
  output logic              ard_receive_ready,
  output logic              err
);

  resp_state_t       state;
  xfer_kind_t        kind;
  logic [BYTE_W-1:0] addr_lo;
  logic [BYTE_W-1:0] wdata_lo;
  logic [BYTE_W-1:0] data_hi;
  logic [ADDR_W-1:0] addr;

  // A CPU write that lost the port to a same-edge ld at a different address
  // is parked here and retired on the next edge without ld_en.
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [WORD_W-1:0] pend_data;

  logic [1:0]        strobe_cnt;
  logic              one_strobe;
  logic              multi_strobe;
  xfer_kind_t        byte_kind;
  logic              accept;
  logic              kind_ok;
  logic              cpu_commit;
  logic [ADDR_W-1:0] req_addr;
  logic              rd_en;
  logic [WORD_W-1:0] rd_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;

  // Strobe decode and byte-accept qualification for the current cycle.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the block can infer a latch.
    strobe_cnt   = 2'(bus_pc) + 2'(bus_mar) + 2'(bus_mdr);
    one_strobe   = (strobe_cnt == 2'd1);
    multi_strobe = (strobe_cnt > 2'd1);
    byte_kind    = strobe_kind(bus_pc, bus_mar);

    // Address-hi and write-hi bytes wait while a parked write is pending,
    // so no read can overtake it and at most one write is ever parked.
    ard_receive_ready = 1'b0;
    unique case (state)
      IDLE, WDATA_LO:    ard_receive_ready = !halt;
      ADDR_HI, WDATA_HI: ard_receive_ready = !halt && !pend_valid;
      default:           ard_receive_ready = 1'b0;
    endcase

    accept     = ard_receive_ready && one_strobe;
    kind_ok    = (state == IDLE) || (byte_kind == kind);
    cpu_commit = accept && kind_ok && (state == WDATA_HI) && !rst;
    req_addr   = ADDR_W'({cpu_bus, addr_lo});
    rd_en      = accept && kind_ok && (state == ADDR_HI) && (kind != XFER_MDR);
  end

  // Write-port arbitration: loader first, then a parked CPU write, then a
  // CPU write committing this edge (never concurrent with a parked one).
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
    if (ld_en) begin
      mem_we = 1'b1;
    end else if (pend_valid) begin
      mem_we    = 1'b1;
      mem_waddr = pend_addr;
      mem_wdata = pend_data;
    end else if (cpu_commit) begin
      mem_we    = 1'b1;
      mem_waddr = addr;
      mem_wdata = {cpu_bus, wdata_lo};
    end
  end

  // Park a CPU write displaced by ld; drop it once written or overwritten by ld.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
    end else if (cpu_commit && ld_en && (ld_addr != addr)) begin
      pend_valid <= 1'b1;
      pend_addr  <= addr;
      pend_data  <= {cpu_bus, wdata_lo};
    end else if (pend_valid && (!ld_en || (ld_addr == pend_addr))) begin
      pend_valid <= 1'b0;
    end
  end

  // Protocol FSM with registered response outputs and sticky error flag.
  // NOTE: state is updated with non-blocking assignments so every register
  // here samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      err            <= 1'b0;
      rsp_bus        <= '0;
      ard_data_ready <= 1'b0;
    end else if (halt) begin
      state          <= IDLE;
      rsp_bus        <= '0;
      ard_data_ready <= 1'b0;
    end else begin
      if (ard_receive_ready && multi_strobe) err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (accept) begin
            kind    <= byte_kind;
            addr_lo <= cpu_bus;
            state   <= ADDR_HI;
          end
        end
        ADDR_HI: begin
          if (accept) begin
            if (!kind_ok) begin
              err   <= 1'b1;
              state <= IDLE;
            end else if (kind == XFER_MDR) begin
              addr  <= req_addr;
              state <= WDATA_LO;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        WDATA_LO: begin
          if (accept) begin
            if (!kind_ok) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              wdata_lo <= cpu_bus;
              state    <= WDATA_HI;
            end
          end
        end
        WDATA_HI: begin
          if (accept) begin
            if (!kind_ok) err <= 1'b1;
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          ard_data_ready <= 1'b1;
          rsp_bus        <= rd_data[BYTE_W-1:0];
          data_hi        <= rd_data[WORD_W-1:BYTE_W];
          state          <= SEND_LO;
        end
        SEND_LO: begin
          if (cpu_rd_ack) begin
            rsp_bus <= data_hi;
            state   <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (cpu_rd_ack) begin
            rsp_bus        <= '0;
            ard_data_ready <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (req_addr),
    .rd_data (rd_data),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata)
  );

endmodule
